// File: rtl/tlb.sv
// Fully associative TLB with two independent combinational search ports,
// a write port, a registered read port and INVTLB-style invalidation.
module tlb #(
  parameter int TLBNUM = 16,
  localparam int IDXW = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,

  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  input  logic [9:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [5:0]      s0_ps,
  output logic [19:0]     s0_ppn,
  output logic [1:0]      s0_plv,
  output logic [1:0]      s0_mat,
  output logic            s0_d,
  output logic            s0_v,

  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  input  logic [9:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [5:0]      s1_ps,
  output logic [19:0]     s1_ppn,
  output logic [1:0]      s1_plv,
  output logic [1:0]      s1_mat,
  output logic            s1_d,
  output logic            s1_v,

  input  logic            invtlb_valid,
  input  logic [4:0]      invtlb_op,
  input  logic [9:0]      invtlb_asid,
  input  logic [18:0]     invtlb_vppn,

  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic [88:0]     w_entry,

  input  logic [IDXW-1:0] r_index,
  output logic [88:0]     r_entry
);

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } entry_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] index;
    logic [5:0]      ps;
    logic [19:0]     ppn;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } result_t;

  entry_t entries [TLBNUM];

  // Huge (ps=21) pages compare only the upper ten VPPN bits.
  function automatic logic va_match(input entry_t ent, input logic [18:0] vppn);
    if (ent.ps == 6'd21)
      return ent.vppn[18:9] == vppn[18:9];
    return ent.vppn == vppn;
  endfunction

  logic [18:0] s_vppn  [2];
  logic        s_bit12 [2];
  logic [9:0]  s_asid  [2];
  result_t [1:0] res;

  assign s_vppn[0]  = s0_vppn;
  assign s_vppn[1]  = s1_vppn;
  assign s_bit12[0] = s0_va_bit12;
  assign s_bit12[1] = s1_va_bit12;
  assign s_asid[0]  = s0_asid;
  assign s_asid[1]  = s1_asid;

  for (genvar p = 0; p < 2; p++) begin : g_search
    logic [TLBNUM-1:0] hit;
    logic              any_hit;
    logic [IDXW-1:0]   hit_idx;
    entry_t            sel;
    logic              odd;
    result_t           r;

    always_comb begin
      for (int i = 0; i < TLBNUM; i++) begin
        hit[i] = entries[i].e
               && (entries[i].g || (entries[i].asid == s_asid[p]))
               && va_match(entries[i], s_vppn[p]);
      end
    end

    // Scan downward so the lowest matching index is the last one kept.
    always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (hit[i]) begin
          any_hit = 1'b1;
          hit_idx = IDXW'(i);
        end
      end
    end

    always_comb begin
      sel = entries[hit_idx];
      odd = (sel.ps == 6'd21) ? s_vppn[p][8] : s_bit12[p];
      r   = '0;
      if (any_hit) begin
        r.found = 1'b1;
        r.index = hit_idx;
        r.ps    = sel.ps;
        if (odd) begin
          r.ppn = sel.ppn1;
          r.plv = sel.plv1;
          r.mat = sel.mat1;
          r.d   = sel.d1;
          r.v   = sel.v1;
        end else begin
          r.ppn = sel.ppn0;
          r.plv = sel.plv0;
          r.mat = sel.mat0;
          r.d   = sel.d0;
          r.v   = sel.v0;
        end
      end
    end

    assign res[p] = r;
  end

  assign s0_found = res[0].found;
  assign s0_index = res[0].index;
  assign s0_ps    = res[0].ps;
  assign s0_ppn   = res[0].ppn;
  assign s0_plv   = res[0].plv;
  assign s0_mat   = res[0].mat;
  assign s0_d     = res[0].d;
  assign s0_v     = res[0].v;

  assign s1_found = res[1].found;
  assign s1_index = res[1].index;
  assign s1_ps    = res[1].ps;
  assign s1_ppn   = res[1].ppn;
  assign s1_plv   = res[1].plv;
  assign s1_mat   = res[1].mat;
  assign s1_d     = res[1].d;
  assign s1_v     = res[1].v;

  logic [TLBNUM-1:0] inv_hit;

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      logic asid_eq;
      logic va_eq;
      logic cond;
      asid_eq = entries[i].asid == invtlb_asid;
      va_eq   = va_match(entries[i], invtlb_vppn);
      case (invtlb_op)
        5'd0, 5'd1: cond = 1'b1;
        5'd2:       cond = entries[i].g;
        5'd3:       cond = !entries[i].g;
        5'd4:       cond = !entries[i].g && asid_eq;
        5'd5:       cond = !entries[i].g && asid_eq && va_eq;
        5'd6:       cond = (entries[i].g || asid_eq) && va_eq;
        default:    cond = 1'b0;
      endcase
      inv_hit[i] = invtlb_valid && cond;
    end
  end

  // Invalidation is computed on pre-edge contents; the write is issued last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
      r_entry <= '0;
    end else begin
      r_entry <= entries[r_index];
      for (int i = 0; i < TLBNUM; i++) begin
        if (inv_hit[i]) entries[i].e <= 1'b0;
      end
      if (we) entries[w_index] <= w_entry;
    end
  end

endmodule

// File: tb/tb_tlb.sv
// Directed, table-driven bench for the tlb: each vector drives one cycle and
// checks the combinational search results just before the committing edge.
module tb_tlb;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] s0_vppn, s1_vppn;
  logic        s0_va_bit12, s1_va_bit12;
  logic [9:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [5:0]  s0_ps, s1_ps;
  logic [19:0] s0_ppn, s1_ppn;
  logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        invtlb_valid;
  logic [4:0]  invtlb_op;
  logic [9:0]  invtlb_asid;
  logic [18:0] invtlb_vppn;
  logic        we;
  logic [3:0]  w_index;
  logic [88:0] w_entry;
  logic [3:0]  r_index;
  logic [88:0] r_entry;

  int nchecks = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  tlb #(.TLBNUM(16)) dut (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_ps(s0_ps), .s0_ppn(s0_ppn),
    .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ps(s1_ps), .s1_ppn(s1_ppn),
    .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
    .invtlb_asid(invtlb_asid), .invtlb_vppn(invtlb_vppn),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry)
  );

  typedef struct packed {
    logic        found;
    logic [3:0]  idx;
    logic [5:0]  ps;
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } res_t;

  typedef struct {
    logic        we;
    logic [3:0]  w_index;
    logic [88:0] w_entry;
    logic        inv_valid;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;
    logic [3:0]  r_index;
    logic [18:0] s0_vppn;
    logic        s0_b12;
    logic [9:0]  s0_asid;
    logic [18:0] s1_vppn;
    logic        s1_b12;
    logic [9:0]  s1_asid;
    res_t        exp0;
    res_t        exp1;
    logic        chk_r;
    logic [88:0] exp_r;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  function automatic logic [88:0] mk_entry(
    input logic e, input logic [18:0] vppn, input logic [5:0] ps,
    input logic [9:0] asid, input logic g,
    input logic [19:0] ppn0, input logic [1:0] plv0, input logic [1:0] mat0,
    input logic d0, input logic v0,
    input logic [19:0] ppn1, input logic [1:0] plv1, input logic [1:0] mat1,
    input logic d1, input logic v1);
    return {e, vppn, ps, asid, g, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1};
  endfunction

  function automatic res_t hit(input logic [3:0] idx, input logic [5:0] ps,
    input logic [19:0] ppn, input logic [1:0] plv, input logic [1:0] mat,
    input logic d, input logic v);
    return {1'b1, idx, ps, ppn, plv, mat, d, v};
  endfunction

  function automatic vec_t blank();
    vec_t b;
    b.we = 0; b.w_index = 0; b.w_entry = '0;
    b.inv_valid = 0; b.inv_op = 0; b.inv_asid = 0; b.inv_vppn = 0;
    b.r_index = 0;
    b.s0_vppn = 0; b.s0_b12 = 0; b.s0_asid = 0;
    b.s1_vppn = 0; b.s1_b12 = 0; b.s1_asid = 0;
    b.exp0 = '0; b.exp1 = '0; b.chk_r = 0; b.exp_r = '0;
    return b;
  endfunction

  function automatic res_t get_res(input int port);
    if (port == 0)
      return {s0_found, s0_index, s0_ps, s0_ppn, s0_plv, s0_mat, s0_d, s0_v};
    return {s1_found, s1_index, s1_ps, s1_ppn, s1_plv, s1_mat, s1_d, s1_v};
  endfunction

  task automatic applyStimulus(input vec_t v);
    we = v.we; w_index = v.w_index; w_entry = v.w_entry;
    invtlb_valid = v.inv_valid; invtlb_op = v.inv_op;
    invtlb_asid = v.inv_asid; invtlb_vppn = v.inv_vppn;
    r_index = v.r_index;
    s0_vppn = v.s0_vppn; s0_va_bit12 = v.s0_b12; s0_asid = v.s0_asid;
    s1_vppn = v.s1_vppn; s1_va_bit12 = v.s1_b12; s1_asid = v.s1_asid;
  endtask

  task automatic checkOutput(input string name, input logic [88:0] act, input logic [88:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [88:0] e3, e0, e2, e4_old, e4_new;

  initial begin
    e3     = mk_entry(1, 19'h00010, 6'd12, 10'd5,    0, 20'h12345, 2'd0, 2'd0, 0, 1, 20'h54321, 2'd0, 2'd0, 1, 1);
    e0     = mk_entry(1, 19'h7FE00, 6'd21, 10'd7,    1, 20'h0AAAA, 2'd1, 2'd1, 0, 1, 20'h0BBBB, 2'd3, 2'd2, 0, 1);
    e2     = mk_entry(1, 19'h01234, 6'd12, 10'h033,  0, 20'h11111, 2'd0, 2'd0, 0, 1, 20'h22222, 2'd0, 2'd0, 0, 1);
    e4_old = mk_entry(1, 19'h00400, 6'd12, 10'd1,    0, 20'h44444, 2'd0, 2'd0, 0, 1, 20'h00000, 2'd0, 2'd0, 0, 0);
    e4_new = mk_entry(1, 19'h00500, 6'd12, 10'd1,    0, 20'h55555, 2'd2, 2'd1, 1, 1, 20'h00000, 2'd0, 2'd0, 0, 0);

    for (int i = 0; i < NVEC; i++) vecs[i] = blank();

    vecs[0].we = 1; vecs[0].w_index = 3; vecs[0].w_entry = e3;
    vecs[0].s0_vppn = 19'h00010; vecs[0].s0_b12 = 1; vecs[0].s0_asid = 10'd5;
    vecs[0].s1_vppn = 19'h00010; vecs[0].s1_b12 = 1; vecs[0].s1_asid = 10'd6;

    vecs[1].we = 1; vecs[1].w_index = 0; vecs[1].w_entry = e0;
    vecs[1].s0_vppn = 19'h00010; vecs[1].s0_b12 = 1; vecs[1].s0_asid = 10'd5;
    vecs[1].s1_vppn = 19'h00010; vecs[1].s1_b12 = 1; vecs[1].s1_asid = 10'd6;
    vecs[1].exp0 = hit(3, 12, 20'h54321, 0, 0, 1, 1);

    vecs[2].we = 1; vecs[2].w_index = 2; vecs[2].w_entry = e2; vecs[2].r_index = 0;
    vecs[2].s0_vppn = 19'h7FFFF; vecs[2].s0_b12 = 0; vecs[2].s0_asid = 10'd9;
    vecs[2].s1_vppn = 19'h7FEFF; vecs[2].s1_b12 = 1; vecs[2].s1_asid = 10'd9;
    vecs[2].exp0 = hit(0, 21, 20'h0BBBB, 3, 2, 0, 1);
    vecs[2].exp1 = hit(0, 21, 20'h0AAAA, 1, 1, 0, 1);

    vecs[3].we = 1; vecs[3].w_index = 9; vecs[3].w_entry = e2;
    vecs[3].chk_r = 1; vecs[3].exp_r = e0;
    vecs[3].s0_vppn = 19'h01234; vecs[3].s0_b12 = 0; vecs[3].s0_asid = 10'h033;
    vecs[3].s1_vppn = 19'h00010; vecs[3].s1_b12 = 0; vecs[3].s1_asid = 10'd5;
    vecs[3].exp0 = hit(2, 12, 20'h11111, 0, 0, 0, 1);
    vecs[3].exp1 = hit(3, 12, 20'h12345, 0, 0, 0, 1);

    vecs[4].inv_valid = 1; vecs[4].inv_op = 5; vecs[4].inv_asid = 10'h033; vecs[4].inv_vppn = 19'h01234;
    vecs[4].s0_vppn = 19'h01234; vecs[4].s0_b12 = 0; vecs[4].s0_asid = 10'h033;
    vecs[4].s1_vppn = 19'h01234; vecs[4].s1_b12 = 1; vecs[4].s1_asid = 10'h033;
    vecs[4].exp0 = hit(2, 12, 20'h11111, 0, 0, 0, 1);
    vecs[4].exp1 = hit(2, 12, 20'h22222, 0, 0, 0, 1);

    vecs[5].inv_valid = 1; vecs[5].inv_op = 7;
    vecs[5].s0_vppn = 19'h01234; vecs[5].s0_b12 = 0; vecs[5].s0_asid = 10'h033;
    vecs[5].s1_vppn = 19'h00010; vecs[5].s1_b12 = 1; vecs[5].s1_asid = 10'd5;
    vecs[5].exp1 = hit(3, 12, 20'h54321, 0, 0, 1, 1);

    vecs[6].inv_valid = 1; vecs[6].inv_op = 2;
    vecs[6].s0_vppn = 19'h7FFFF; vecs[6].s0_b12 = 0; vecs[6].s0_asid = 10'd9;
    vecs[6].s1_vppn = 19'h00010; vecs[6].s1_b12 = 1; vecs[6].s1_asid = 10'd5;
    vecs[6].exp0 = hit(0, 21, 20'h0BBBB, 3, 2, 0, 1);
    vecs[6].exp1 = hit(3, 12, 20'h54321, 0, 0, 1, 1);

    vecs[7].we = 1; vecs[7].w_index = 4; vecs[7].w_entry = e4_old;
    vecs[7].s0_vppn = 19'h7FFFF; vecs[7].s0_b12 = 0; vecs[7].s0_asid = 10'd9;
    vecs[7].s1_vppn = 19'h00010; vecs[7].s1_b12 = 1; vecs[7].s1_asid = 10'd5;
    vecs[7].exp1 = hit(3, 12, 20'h54321, 0, 0, 1, 1);

    vecs[8].we = 1; vecs[8].w_index = 4; vecs[8].w_entry = e4_new;
    vecs[8].inv_valid = 1; vecs[8].inv_op = 0; vecs[8].r_index = 4;
    vecs[8].s0_vppn = 19'h00400; vecs[8].s0_b12 = 0; vecs[8].s0_asid = 10'd1;
    vecs[8].s1_vppn = 19'h00010; vecs[8].s1_b12 = 1; vecs[8].s1_asid = 10'd5;
    vecs[8].exp0 = hit(4, 12, 20'h44444, 0, 0, 0, 1);
    vecs[8].exp1 = hit(3, 12, 20'h54321, 0, 0, 1, 1);

    vecs[9].r_index = 4; vecs[9].chk_r = 1; vecs[9].exp_r = e4_old;
    vecs[9].s0_vppn = 19'h00500; vecs[9].s0_b12 = 0; vecs[9].s0_asid = 10'd1;
    vecs[9].s1_vppn = 19'h00010; vecs[9].s1_b12 = 1; vecs[9].s1_asid = 10'd5;
    vecs[9].exp0 = hit(4, 12, 20'h55555, 2, 1, 1, 1);

    vecs[10].chk_r = 1; vecs[10].exp_r = e4_new;
    vecs[10].s0_vppn = 19'h00400; vecs[10].s0_b12 = 0; vecs[10].s0_asid = 10'd1;
    vecs[10].s1_vppn = 19'h7FFFF; vecs[10].s1_b12 = 0; vecs[10].s1_asid = 10'd9;

    reset = 1'b1;
    applyStimulus(blank());
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #4;
    checkOutput("reset s0", 89'(get_res(0)), 89'(res_t'('0)));
    checkOutput("reset s1", 89'(get_res(1)), 89'(res_t'('0)));
    checkOutput("reset r_entry", r_entry, '0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #4;
      checkOutput($sformatf("vec%0d s0", i), 89'(get_res(0)), 89'(vecs[i].exp0));
      checkOutput($sformatf("vec%0d s1", i), 89'(get_res(1)), 89'(vecs[i].exp1));
      if (vecs[i].chk_r)
        checkOutput($sformatf("vec%0d r_entry", i), r_entry, vecs[i].exp_r);
    end

    // Reset held across an edge that also carries a write: nothing lands.
    @(negedge clk);
    applyStimulus(blank());
    reset = 1'b1;
    we = 1'b1; w_index = 4'd5; w_entry = e3;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(blank());
    s0_vppn = 19'h00010; s0_va_bit12 = 1'b1; s0_asid = 10'd5;
    s1_vppn = 19'h00500; s1_va_bit12 = 1'b0; s1_asid = 10'd1;
    #4;
    checkOutput("post-reset s0", 89'(get_res(0)), 89'(res_t'('0)));
    checkOutput("post-reset s1", 89'(get_res(1)), 89'(res_t'('0)));
    checkOutput("post-reset r_entry", r_entry, '0);
    @(negedge clk);
    s0_vppn = 19'h7FFFF; s0_va_bit12 = 1'b0; s0_asid = 10'd9;
    s1_vppn = 19'h01234; s1_va_bit12 = 1'b0; s1_asid = 10'h033;
    #4;
    checkOutput("post-reset s0 huge", 89'(get_res(0)), 89'(res_t'('0)));
    checkOutput("post-reset s1 e2", 89'(get_res(1)), 89'(res_t'('0)));

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/tlb.md
TLB -- requirements
Module: tlb

Interface
REQ-001 SHALL provide parameter TLBNUM, default 16, number of entries; index width is 4 bits for the default.
REQ-002 SHALL provide port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL provide ports s0_vppn / s1_vppn  in  19  search VA[31:13], port 0 for fetch, port 1 for load/store/tlbsrch.
REQ-005 SHALL provide ports s0_va_bit12 / s1_va_bit12  in  1  search VA[12].
REQ-006 SHALL provide ports s0_asid / s1_asid  in  10  current ASID.
REQ-007 SHALL provide ports s0_found / s1_found  out  1  a valid entry matched.
REQ-008 SHALL provide ports s0_index / s1_index  out  4  index of the matching entry.
REQ-009 SHALL provide ports s0_ps / s1_ps  out  6  page size of the matching entry.
REQ-010 SHALL provide ports s0_ppn, s0_plv, s0_mat, s0_d, s0_v (and s1_*)  out  20/2/2/1/1  selected physical-page fields.
REQ-011 SHALL provide port invtlb_valid  in  1  INVTLB request this cycle.
REQ-012 SHALL provide port invtlb_op  in  5  INVTLB op code.
REQ-013 SHALL provide ports invtlb_asid / invtlb_vppn  in  10/19  INVTLB ASID and VA[31:13] operands.
REQ-014 SHALL provide port we  in  1  write entry (TLBWR/TLBFILL).
REQ-015 SHALL provide port w_index  in  4  entry index to write.
REQ-016 SHALL provide port w_entry  in  89  packed entry {e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0, mat0, d0, v0, ppn1[19:0], plv1, mat1, d1, v1}, MSB first.
REQ-017 SHALL provide port r_index  in  4  entry index to read (TLBRD).
REQ-018 SHALL provide port r_entry  out  89  registered read data, same packing as w_entry.

Function
REQ-019 Entry i SHALL match a search when e=1, (g=1 or asid==s_asid), and vppn equal on bits [18:0] if ps==12, or on bits [18:9] if ps==21.
REQ-020 Search SHALL be combinational from s*_ inputs and current entry state; zero-cycle latency.
REQ-021 Odd-page select SHALL be s_va_bit12 when ps==12, s_vppn[8] when ps==21; odd selects the ppn1 group, even selects the ppn0 group.
REQ-022 On multiple matches, the lowest index SHALL win.
REQ-023 With no match, found, index, ps, ppn, plv, mat, d and v SHALL all be 0.
REQ-024 When we=1, entry[w_index] SHALL be replaced by w_entry at the clock edge; searches see the new value from the next cycle, with no bypass.
REQ-025 When invtlb_valid=1, e SHALL be cleared at the edge for every entry meeting the op condition; all other fields are unchanged.
REQ-026 INVTLB op conditions SHALL be: 0,1 = all entries; 2 = g=1; 3 = g=0; 4 = g=0 and asid match; 5 = g=0, asid match and VA match; 6 = (g=1 or asid match) and VA match; any other op = no effect.
REQ-027 The INVTLB VA match SHALL use the same ps-dependent rule as REQ-019, applied to invtlb_vppn.
REQ-028 If we and invtlb_valid occur in the same cycle, INVTLB SHALL be evaluated on pre-edge contents, and the write to w_index SHALL then take precedence.
REQ-029 r_entry SHALL equal the pre-edge contents of entry[r_index] sampled every cycle, giving 1-cycle latency; a same-cycle write is not forwarded.
REQ-030 Search ports 0 and 1 SHALL be fully independent and may hit the same entry simultaneously.

Reset
REQ-031 While reset=1 at an edge, every entry SHALL be cleared to all-zero (e=0) and r_entry to 0; reset dominates we and invtlb_valid.
REQ-032 In the cycle after reset, s0_found and s1_found SHALL be 0 for any input.

Verification
REQ-033 Bench SHALL cover: reset, then write index 3 with {e=1, vppn=0x00010, ps=12, asid=5, g=0, ppn0=0x12345, v0=1, ppn1=0x54321, v1=1, d1=1}, then search vppn=0x00010, bit12=1, asid=5 -> found=1, index=3, ppn=0x54321, d=1; same search with asid=6 -> found=0, all outputs 0.
REQ-034 Bench SHALL cover: ps=21 entry with vppn=0x7FE00 at index 0, search vppn=0x7FFFF -> found, odd page selected by vppn[8]=1, while va_bit12 is ignored.
REQ-035 Bench SHALL cover: identical valid entries at indices 2 and 9, search hits -> index=2; INVTLB op 5 with a matching asid/vppn on g=0 entries -> both e bits cleared, and the next-cycle search misses.
REQ-036 Bench SHALL cover: same cycle we to index 4 and INVTLB op 0 -> entry 4 valid, all others e=0; r_index=4 in that cycle -> r_entry shows the old entry 4 next cycle.
REQ-037 Bench SHALL cover: reset asserted in a cycle with we=1 -> no entry is written, and all searches miss afterwards.
